hamming74_serial_encoder: RTL and testbench
===========================================

HAMMING74_SERIAL_ENCODER -- requirements
Module: hamming74_serial_encoder

Interface
REQ-001 SHALL have parameters: none; code fixed at (7,4) cyclic Hamming, g(x)=x^3+x+1.
REQ-002 SHALL have port clk  input  1  rising-edge clock.
REQ-003 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port data_in  input  1  serial message bit, MSB (m3) first.
REQ-005 SHALL have port in_valid  input  1  data_in valid this cycle.
REQ-006 SHALL have port in_ready  output  1  encoder accepts data_in this cycle.
REQ-007 SHALL have port data_out  output  1  serial codeword bit, c6 first.
REQ-008 SHALL have port out_valid  output  1  data_out valid.
REQ-009 SHALL have port frame_start  output  1  high with the c6 bit of each codeword.

Function
REQ-010 SHALL be systematic: codeword c6..c0 = m3 m2 m1 m0 p2 p1 p0, where p2 p1 p0 is the remainder of x^3*m(x) mod g(x).
REQ-011 SHALL use FSM states IDLE, MSG, PAR; IDLE->MSG on the first accepted bit; MSG->PAR after the 4th accepted bit; PAR->IDLE after the 3rd parity bit is output.
REQ-012 SHALL drive in_ready = 1 in IDLE and MSG, 0 in PAR; a bit is accepted only when in_valid && in_ready.
REQ-013 SHALL ignore in_valid while in PAR.
REQ-014 SHALL hold state, bit counter and remainder in MSG when in_valid=0 (stall); out_valid SHALL be 0 on the following cycle.
REQ-015 SHALL register outputs: an accepted message bit appears on data_out with out_valid=1 exactly one cycle after acceptance.
REQ-016 SHALL update the remainder (r2,r1,r0) per accepted bit: fb = data_in ^ r2; r0<=fb; r1<=r0^fb; r2<=r1.
REQ-017 SHALL, in PAR, output r2 each cycle and then shift r2<=r1, r1<=r0, r0<=0, with out_valid=1 on 3 consecutive cycles immediately following the m0 output cycle.
REQ-018 SHALL clear the remainder and the bit counter on PAR->IDLE so that the next frame starts from zero.
REQ-019 SHALL support back-to-back frames: with in_valid held high, each codeword is 7 contiguous valid output cycles, and in_ready is low for exactly 3 cycles per frame.
REQ-020 SHALL assert frame_start only together with out_valid for bit c6.

Reset
REQ-021 SHALL, on rst_n=0, immediately force: state=IDLE, in_ready=1 after the asynchronous clear, data_out=0, out_valid=0, frame_start=0, remainder=000, counter=0.
REQ-022 SHALL discard any partial frame on reset mid-operation; no residual parity bits SHALL be emitted afterwards.

Configuration
REQ-023 SHALL support macro HAMMING_ERR_INJ_EN; when defined, adds inputs err_inject (1) and err_pos (3); err_pos is sampled with the first accepted bit of a frame when err_inject=1, and output bit c(err_pos-1) is inverted (err_pos=1..7 maps to c0..c6; 0 = no flip).
REQ-024 SHALL, without HAMMING_ERR_INJ_EN, omit both ports and never modify codeword bits.

Structure
REQ-025 SHALL place N=7, K=4, R=3, the generator constant 4'b1011 and the FSM state enum in shared package hamming74_pkg.
REQ-026 SHALL implement the 3-bit divider/shifter of REQ-016/REQ-017 as sub-module hamming74_lfsr (ports: clk, rst_n, clr, shift_in_en, shift_out_en, din, dout).

Verification
REQ-027 SHALL cover: message 1000, in_valid continuous -> data_out 1000101; frame_start on the first bit.
REQ-028 SHALL cover: messages 0000, 1111, 0001, 1101 back-to-back -> codewords 0000000, 1111111, 0001011, 1101001 with no gaps; in_ready low for 3 cycles per frame.
REQ-029 SHALL cover: message 1101 with in_valid deasserted 2 cycles after m2 -> out_valid gap of 2 cycles; codeword is still 1101001.
REQ-030 SHALL cover: rst_n pulse after 2 message bits, then message 0001 -> only 0001011 is output; no stray parity bits.
REQ-031 SHALL cover (HAMMING_ERR_INJ_EN): message 1000, err_inject=1, err_pos=3 -> 1000001; loopback into the (7,4) decoder recovers 1000.
REQ-032 SHALL cover: in_valid=1 during PAR with data_in toggling -> parity bits unaffected; the next frame begins only when in_ready returns to 1.

Source files
------------

// File: rtl/hamming74_pkg.sv
// Shared constants and FSM state type for the (7,4) cyclic Hamming encoder.
package hamming74_pkg;
  localparam int N = 7;
  localparam int K = 4;
  localparam int R = 3;
  // g(x) = x^3 + x + 1, MSB is the x^3 term
  localparam logic [3:0] GEN_POLY = 4'b1011;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MSG  = 2'd1,
    PAR  = 2'd2
  } state_e;
endpackage

// File: rtl/hamming74_lfsr.sv
// 3-bit polynomial divider: shift_in_en divides by g(x), shift_out_en drains the remainder MSB-first.
// State changes one cycle after an enable; clr has priority over both shifts.
module hamming74_lfsr
  import hamming74_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic shift_in_en,
  input  logic shift_out_en,
  input  logic din,
  output logic dout
);

  logic [R-1:0] r_q, r_d;
  logic         fb;

  always_comb begin
    fb  = din ^ r_q[R-1];
    r_d = r_q;
    if (clr) begin
      r_d = '0;
    end else if (shift_in_en) begin
      // Feedback taps come from the low generator coefficients.
      r_d = {r_q[R-2:0], 1'b0} ^ ({R{fb}} & GEN_POLY[R-1:0]);
    end else if (shift_out_en) begin
      r_d = {r_q[R-2:0], 1'b0};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_q <= '0;
    else        r_q <= r_d;
  end

  assign dout = r_q[R-1];

endmodule

// File: rtl/hamming74_serial_encoder.sv
// Serial systematic (7,4) Hamming encoder: message bits out 1 cycle after acceptance, parity follows m0 directly.
// in_ready drops for the 3 parity cycles; HAMMING_ERR_INJ_EN adds err_inject/err_pos single-bit corruption.
module hamming74_serial_encoder
  import hamming74_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       data_in,
  input  logic       in_valid,
`ifdef HAMMING_ERR_INJ_EN
  input  logic       err_inject,
  input  logic [2:0] err_pos,
`endif
  output logic       in_ready,
  output logic       data_out,
  output logic       out_valid,
  output logic       frame_start
);

  state_e     state_q, state_d;
  logic [1:0] cnt_q, cnt_d;
  logic       dout_q, dout_d;
  logic       vld_q, vld_d;
  logic       fs_q, fs_d;
  logic       accept;
  logic       lfsr_clr, lfsr_in, lfsr_out, par_bit;
  logic       flip;

  assign in_ready = (state_q != PAR);
  assign accept   = in_valid && in_ready;

`ifdef HAMMING_ERR_INJ_EN
  logic [2:0] epos_q, epos_d, epos_sel, out_pos;

  // The frame's first bit uses err_pos directly; later bits use the latched copy.
  assign epos_sel = (state_q == IDLE) ? (err_inject ? err_pos : 3'd0) : epos_q;
  assign epos_d   = (state_q == IDLE && accept) ? epos_sel : epos_q;

  // out_pos is the codeword index + 1 of the bit being emitted (7 = c6).
  always_comb begin
    out_pos = 3'd7;
    case (state_q)
      MSG:     out_pos = 3'd7 - {1'b0, cnt_q};
      PAR:     out_pos = 3'd3 - {1'b0, cnt_q};
      default: out_pos = 3'd7;
    endcase
  end

  assign flip = vld_d && (epos_sel != 3'd0) && (epos_sel == out_pos);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) epos_q <= 3'd0;
    else        epos_q <= epos_d;
  end
`else
  assign flip = 1'b0;
`endif

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    dout_d   = dout_q;
    vld_d    = 1'b0;
    fs_d     = 1'b0;
    lfsr_clr = 1'b0;
    lfsr_in  = 1'b0;
    lfsr_out = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          lfsr_in = 1'b1;
          dout_d  = data_in;
          vld_d   = 1'b1;
          fs_d    = 1'b1;
          cnt_d   = 2'd1;
          state_d = MSG;
        end
      end
      MSG: begin
        if (accept) begin
          lfsr_in = 1'b1;
          dout_d  = data_in;
          vld_d   = 1'b1;
          if (cnt_q == 2'd3) begin
            cnt_d   = 2'd0;
            state_d = PAR;
          end else begin
            cnt_d = cnt_q + 2'd1;
          end
        end
      end
      PAR: begin
        lfsr_out = 1'b1;
        dout_d   = par_bit;
        vld_d    = 1'b1;
        if (cnt_q == 2'd2) begin
          cnt_d    = 2'd0;
          lfsr_clr = 1'b1;
          state_d  = IDLE;
        end else begin
          cnt_d = cnt_q + 2'd1;
        end
      end
      default: begin
        cnt_d    = 2'd0;
        lfsr_clr = 1'b1;
        state_d  = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= 2'd0;
      dout_q  <= 1'b0;
      vld_q   <= 1'b0;
      fs_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      dout_q  <= dout_d ^ flip;
      vld_q   <= vld_d;
      fs_q    <= fs_d;
    end
  end

  hamming74_lfsr u_lfsr (
    .clk          (clk),
    .rst_n        (rst_n),
    .clr          (lfsr_clr),
    .shift_in_en  (lfsr_in),
    .shift_out_en (lfsr_out),
    .din          (data_in),
    .dout         (par_bit)
  );

  assign data_out    = dout_q;
  assign out_valid   = vld_q;
  assign frame_start = fs_q;

endmodule

// File: tb/tb_hamming74_serial_encoder.sv
// Randomized and directed bench for hamming74_serial_encoder against a polynomial-division reference.
module tb_hamming74_serial_encoder;

  logic clk = 1'b0;
  logic rst_n, data_in, in_valid;
  logic in_ready, data_out, out_valid, frame_start;
`ifdef HAMMING_ERR_INJ_EN
  logic       err_inject;
  logic [2:0] err_pos;
`endif

  hamming74_serial_encoder dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .data_in     (data_in),
    .in_valid    (in_valid),
`ifdef HAMMING_ERR_INJ_EN
    .err_inject  (err_inject),
    .err_pos     (err_pos),
`endif
    .in_ready    (in_ready),
    .data_out    (data_out),
    .out_valid   (out_valid),
    .frame_start (frame_start)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic b;
    logic fs;
    logic par;
  } exp_t;

  localparam logic [6:0] G7 = 7'b0001011;

  int         total = 0;
  int         bad = 0;
  int         cyc = 0;
  exp_t       exp_q[$];
  int         acc_q[$];
  logic [3:0] msg_q[$];
  logic [6:0] cw_hist[$];
  logic [6:0] cw_asm, last_cw;
  int         nbits = 0;
  int         vld_cnt, first_cyc, last_cyc, rdy_low;
  int         last_out = -10;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", tag, got, want);
    end
  endtask

  // Remainder of v(x) mod g(x) by long division.
  function automatic logic [2:0] poly_rem(input logic [6:0] v);
    logic [6:0] t;
    t = v;
    for (int i = 6; i >= 3; i--)
      if (t[i]) t = t ^ (G7 << (i - 3));
    return t[2:0];
  endfunction

  function automatic logic [6:0] encode(input logic [3:0] m);
    logic [6:0] d;
    d = {m, 3'b000};
    return d | {4'b0000, poly_rem(d)};
  endfunction

  function automatic logic [3:0] decode(input logic [6:0] cw);
    logic [6:0] t;
    if (poly_rem(cw) == 3'b000) return cw[6:3];
    for (int j = 0; j < 7; j++) begin
      t = cw ^ (7'd1 << j);
      if (poly_rem(t) == 3'b000) return t[6:3];
    end
    return cw[6:3];
  endfunction

  always @(posedge clk) cyc = cyc + 1;

  // Output monitor / scoreboard.
  always @(negedge clk) begin
    exp_t       e;
    int         a;
    logic [3:0] m;
    if (rst_n) begin
      if (!in_ready) rdy_low++;
      if (out_valid) begin
        vld_cnt++;
        if (first_cyc < 0) first_cyc = cyc;
        last_cyc = cyc;
        if (exp_q.size() == 0) begin
          chk("stray_out", 1, 0);
        end else begin
          e = exp_q.pop_front();
          chk("dout", data_out, e.b);
          chk("fstart", frame_start, e.fs);
          if (!e.par) begin
            if (acc_q.size() > 0) begin
              a = acc_q.pop_front();
              chk("msg_lat", cyc, a);
            end else begin
              chk("acc_missing", 1, 0);
            end
          end else begin
            chk("par_lat", cyc, last_out + 1);
          end
        end
        last_out = cyc;
        cw_asm = frame_start ? {6'b0, data_out} : {cw_asm[5:0], data_out};
        nbits  = frame_start ? 1 : nbits + 1;
        if (nbits == 7) begin
          last_cw = cw_asm;
          cw_hist.push_back(cw_asm);
          if (msg_q.size() > 0) begin
            m = msg_q.pop_front();
            chk("decode", decode(cw_asm), m);
          end else begin
            chk("no_msg", 1, 0);
          end
        end
      end else begin
        chk("fs_idle", frame_start, 0);
      end
    end
  end

  task automatic win_clear();
    vld_cnt   = 0;
    first_cyc = -1;
    last_cyc  = 0;
    rdy_low   = 0;
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic b, input logic first, input logic [6:0] cw,
                          input logic [3:0] m, input logic [2:0] epos);
    int guard = 0;
    // While in_ready is low keep in_valid high with junk data; it must be ignored.
    while (in_ready !== 1'b1 && guard < 20) begin
      data_in  = 1'($urandom);
      in_valid = 1'b1;
      @(posedge clk);
      #1;
      guard++;
    end
    if (guard >= 20) chk("rdy_timeout", 0, 1);
    data_in  = b;
    in_valid = 1'b1;
`ifdef HAMMING_ERR_INJ_EN
    err_inject = first && (epos != 3'd0);
    err_pos    = first ? epos : 3'($urandom);
`endif
    if (first) begin
      for (int k = 6; k >= 0; k--) exp_q.push_back('{b: cw[k], fs: (k == 6), par: (k < 3)});
      msg_q.push_back(m);
    end
    @(posedge clk);
    #1;
    acc_q.push_back(cyc);
`ifdef HAMMING_ERR_INJ_EN
    err_inject = 1'($urandom) && 1'b0;
    err_pos    = 3'($urandom);
`endif
  endtask

  task automatic send_frame(input logic [3:0] m, input int stall_after, input int stall_len,
                            input logic [2:0] epos);
    logic [6:0] cw;
    cw = encode(m);
    if (epos != 3'd0) cw[epos - 3'd1] = ~cw[epos - 3'd1];
    for (int i = 0; i < 4; i++) begin
      send_bit(m[3 - i], i == 0, cw, m, epos);
      if (i + 1 == stall_after) begin
        in_valid = 1'b0;
        data_in  = 1'($urandom);
        repeat (stall_len) @(posedge clk);
        #1;
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [6:0] want_b2b[4];
    logic [6:0] cw;
    logic [2:0] ep;
    want_b2b = '{7'b0000000, 7'b1111111, 7'b0001011, 7'b1101001};
    rst_n    = 1'b0;
    in_valid = 1'b0;
    data_in  = 1'b0;
`ifdef HAMMING_ERR_INJ_EN
    err_inject = 1'b0;
    err_pos    = 3'd0;
`endif
    #2;
    chk("rst_ready", in_ready, 1);
    chk("rst_vld", out_valid, 0);
    chk("rst_dout", data_out, 0);
    chk("rst_fs", frame_start, 0);
    #10 rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Single frame, continuous valid.
    win_clear();
    send_frame(4'b1000, 0, 0, 3'd0);
    idle(6);
    chk("t1_cw", last_cw, 7'b1000101);
    chk("t1_vld", vld_cnt, 7);

    // Back-to-back frames with in_valid held high.
    win_clear();
    cw_hist.delete();
    send_frame(4'b0000, 0, 0, 3'd0);
    send_frame(4'b1111, 0, 0, 3'd0);
    send_frame(4'b0001, 0, 0, 3'd0);
    send_frame(4'b1101, 0, 0, 3'd0);
    idle(8);
    chk("b2b_n", cw_hist.size(), 4);
    for (int i = 0; i < 4; i++)
      if (i < cw_hist.size()) chk("b2b_cw", cw_hist[i], want_b2b[i]);
    chk("b2b_vld", vld_cnt, 28);
    chk("b2b_span", last_cyc - first_cyc + 1, 28);
    chk("b2b_rdylow", rdy_low, 12);

    // Stall for 2 cycles after m2.
    win_clear();
    send_frame(4'b1101, 2, 2, 3'd0);
    idle(6);
    chk("stall_cw", last_cw, 7'b1101001);
    chk("stall_vld", vld_cnt, 7);
    chk("stall_span", last_cyc - first_cyc + 1, 9);

    // Reset after two message bits, then a clean frame.
    cw = encode(4'b1101);
    send_bit(1'b1, 1'b1, cw, 4'b1101, 3'd0);
    send_bit(1'b1, 1'b0, cw, 4'b1101, 3'd0);
    idle(1);
    rst_n = 1'b0;
    #2;
    chk("mrst_vld", out_valid, 0);
    chk("mrst_ready", in_ready, 1);
    chk("mrst_dout", data_out, 0);
    exp_q.delete();
    acc_q.delete();
    msg_q.delete();
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;
    win_clear();
    send_frame(4'b0001, 0, 0, 3'd0);
    idle(8);
    chk("mrst_cw", last_cw, 7'b0001011);
    chk("mrst_vld7", vld_cnt, 7);

`ifdef HAMMING_ERR_INJ_EN
    send_frame(4'b1000, 0, 0, 3'd3);
    idle(6);
    chk("einj_cw", last_cw, 7'b1000001);
    chk("einj_dec", decode(last_cw), 4'b1000);
`endif

    // Random frames with random stalls and gaps.
    for (int n = 0; n < 40; n++) begin
      ep = 3'd0;
`ifdef HAMMING_ERR_INJ_EN
      ep = 3'($urandom_range(0, 7));
`endif
      send_frame(4'($urandom), $urandom_range(0, 3), $urandom_range(1, 3), ep);
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
    end
    idle(10);
    chk("leftover", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
